// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_arb_pkg;

  localparam int unsigned ADDR_W              = 32;
  localparam int unsigned DATA_W              = 32;
  localparam int unsigned WD_CNT_W            = 8;
  localparam int unsigned DEFAULT_ACK_TIMEOUT = 15;
  localparam logic [1:0]  WORD_ALIGN_MASK     = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    BUSY1,
    BUSY2,
    DONE1,
    DONE2
  } arb_state_t;

  // Command held on the memory side for the duration of an access.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  // True when the byte address is not on a 32-bit word boundary.
  function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
    return (addr[1:0] & WORD_ALIGN_MASK) != 2'b00;
  endfunction

  // Builds the memory command with the address forced to a word boundary.
  function automatic mem_cmd_t make_cmd(input logic              we,
                                        input logic [ADDR_W-1:0] addr,
                                        input logic [DATA_W-1:0] wdata);
    mem_cmd_t cmd;
    cmd.we    = we;
    cmd.addr  = addr & ~ADDR_W'(WORD_ALIGN_MASK);
    cmd.wdata = wdata;
    return cmd;
  endfunction

endpackage

// File: rtl/ack_watchdog.sv
// Saturating cycle counter that flags an access which has waited too long for mem_ack.
module ack_watchdog
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [WD_CNT_W-1:0] cnt;

  // Count un-acknowledged BUSY cycles; clear has priority and the count sticks at all-ones.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != '1)) begin
      cnt <= cnt + WD_CNT_W'(1);
    end
  end

  // Expiry marks the last BUSY cycle the arbiter may wait before aborting.
  assign expired = (cnt == WD_CNT_W'(ACK_TIMEOUT - 1));

endmodule

// File: rtl/dmem_port_arbiter.sv
// Serialises the two issue datapaths onto the single data-memory port, dp1 first.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              dp1_req,
  input  logic              dp1_we,
  input  logic [ADDR_W-1:0] dp1_addr,
  input  logic [DATA_W-1:0] dp1_wdata,
  output logic [DATA_W-1:0] dp1_rdata,
  output logic              dp1_done,
  output logic              dp1_err,
  input  logic              dp2_req,
  input  logic              dp2_we,
  input  logic [ADDR_W-1:0] dp2_addr,
  input  logic [DATA_W-1:0] dp2_wdata,
  output logic [DATA_W-1:0] dp2_rdata,
  output logic              dp2_done,
  output logic              dp2_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_stall
);

  arb_state_t        state, state_d;
  mem_cmd_t          cmd_q, cmd_d;
  logic              mem_req_d;
  logic [DATA_W-1:0] dp1_rdata_d, dp2_rdata_d;
  logic              dp1_done_d, dp2_done_d;
  logic              dp1_err_d, dp2_err_d;
  logic              grant1, grant2;
  logic              busy;
  logic              wd_expired;

  assign busy = (state == BUSY1) || (state == BUSY2);

  // Watchdog is held cleared outside BUSY so every BUSY entry starts from zero.
  ack_watchdog #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_ack_watchdog (
    .clk    (clk),
    .n_rst  (n_rst),
    .clear  (!busy),
    .enable (busy && !mem_ack),
    .expired(wd_expired)
  );

  // Next-state and next-output logic; every registered output is recomputed here.
  always_comb begin
    state_d     = state;
    cmd_d       = cmd_q;
    mem_req_d   = 1'b0;
    dp1_rdata_d = dp1_rdata;
    dp2_rdata_d = dp2_rdata;
    dp1_done_d  = 1'b0;
    dp2_done_d  = 1'b0;
    dp1_err_d   = 1'b0;
    dp2_err_d   = 1'b0;
    grant1      = 1'b0;
    grant2      = 1'b0;

    case (state)
      IDLE: begin
        if (dp1_req) begin
          grant1 = 1'b1;
        end else if (dp2_req) begin
          grant2 = 1'b1;
        end
      end
      BUSY1: begin
        if (mem_ack) begin
          state_d     = DONE1;
          dp1_rdata_d = cmd_q.we ? '0 : mem_rdata;
        end else if (wd_expired) begin
          state_d     = DONE1;
          dp1_err_d   = 1'b1;
          dp1_rdata_d = '0;
        end
      end
      BUSY2: begin
        if (mem_ack) begin
          state_d     = DONE2;
          dp2_rdata_d = cmd_q.we ? '0 : mem_rdata;
        end else if (wd_expired) begin
          state_d     = DONE2;
          dp2_err_d   = 1'b1;
          dp2_rdata_d = '0;
        end
      end
      DONE1: begin
        // dp1 still holds its req here; only dp2 may follow within the bundle.
        if (dp2_req) begin
          grant2 = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      DONE2: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Grants: misaligned accesses bypass memory and complete with an error.
    if (grant1) begin
      if (is_misaligned(dp1_addr)) begin
        state_d     = DONE1;
        dp1_err_d   = 1'b1;
        dp1_rdata_d = '0;
      end else begin
        state_d = BUSY1;
        cmd_d   = make_cmd(dp1_we, dp1_addr, dp1_wdata);
      end
    end
    if (grant2) begin
      if (is_misaligned(dp2_addr)) begin
        state_d     = DONE2;
        dp2_err_d   = 1'b1;
        dp2_rdata_d = '0;
      end else begin
        state_d = BUSY2;
        cmd_d   = make_cmd(dp2_we, dp2_addr, dp2_wdata);
      end
    end

    mem_req_d  = (state_d == BUSY1) || (state_d == BUSY2);
    dp1_done_d = (state_d == DONE1);
    dp2_done_d = (state_d == DONE2);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      cmd_q     <= '0;
      mem_req   <= 1'b0;
      dp1_rdata <= '0;
      dp2_rdata <= '0;
      dp1_done  <= 1'b0;
      dp2_done  <= 1'b0;
      dp1_err   <= 1'b0;
      dp2_err   <= 1'b0;
    end else begin
      state     <= state_d;
      cmd_q     <= cmd_d;
      mem_req   <= mem_req_d;
      dp1_rdata <= dp1_rdata_d;
      dp2_rdata <= dp2_rdata_d;
      dp1_done  <= dp1_done_d;
      dp2_done  <= dp2_done_d;
      dp1_err   <= dp1_err_d;
      dp2_err   <= dp2_err_d;
    end
  end

  assign mem_we    = cmd_q.we;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;

  // Issue stall: held for the whole bundle, released in its final DONE cycle.
  assign mem_stall = ((state == IDLE) && (dp1_req || dp2_req)) ||
                     busy ||
                     ((state == DONE1) && dp2_req);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter (ACK_TIMEOUT = 4).
module tb_dmem_port_arbiter;

  logic        clk;
  logic        n_rst;
  logic        dp1_req, dp1_we;
  logic [31:0] dp1_addr, dp1_wdata, dp1_rdata;
  logic        dp1_done, dp1_err;
  logic        dp2_req, dp2_we;
  logic [31:0] dp2_addr, dp2_wdata, dp2_rdata;
  logic        dp2_done, dp2_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        mem_stall;

  int n_pass;
  int n_total;

  dmem_port_arbiter #(.ACK_TIMEOUT(4)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .dp1_req  (dp1_req),
    .dp1_we   (dp1_we),
    .dp1_addr (dp1_addr),
    .dp1_wdata(dp1_wdata),
    .dp1_rdata(dp1_rdata),
    .dp1_done (dp1_done),
    .dp1_err  (dp1_err),
    .dp2_req  (dp2_req),
    .dp2_we   (dp2_we),
    .dp2_addr (dp2_addr),
    .dp2_wdata(dp2_wdata),
    .dp2_rdata(dp2_rdata),
    .dp2_done (dp2_done),
    .dp2_err  (dp2_err),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .mem_stall(mem_stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    dp1_req = 0; dp1_we = 0; dp1_addr = 0; dp1_wdata = 0;
    dp2_req = 0; dp2_we = 0; dp2_addr = 0; dp2_wdata = 0;
    mem_ack = 0; mem_rdata = 0;
    #12;
    n_total++;
    if ({mem_req, mem_we, dp1_done, dp1_err, dp2_done, dp2_err, mem_stall} !== 7'b0) begin
      $display("FAIL reset_ctrl got=%b exp=0000000",
               {mem_req, mem_we, dp1_done, dp1_err, dp2_done, dp2_err, mem_stall});
    end else n_pass++;
    n_total++;
    if ({mem_addr, mem_wdata, dp1_rdata, dp2_rdata} !== 128'h0) begin
      $display("FAIL reset_data got=%h exp=0", {mem_addr, mem_wdata, dp1_rdata, dp2_rdata});
    end else n_pass++;
    n_rst = 1'b1;
  endtask

  task automatic test_single_load();
    tick();
    // c0
    dp1_req = 1; dp1_we = 0; dp1_addr = 32'h100;
    #1;
    n_total++;
    if ({mem_req, mem_stall} !== 2'b01) begin
      $display("FAIL load_c0 got=%b exp=01", {mem_req, mem_stall});
    end else n_pass++;
    // c1..c3 : mem_req held, ack in c3
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 3) begin mem_ack = 1; mem_rdata = 32'hDEADBEEF; end
      #1;
      n_total++;
      if ({mem_req, mem_we, mem_addr, dp1_done, mem_stall} !== {1'b1, 1'b0, 32'h100, 1'b0, 1'b1}) begin
        $display("FAIL load_busy_c%0d got=%b/%b/%h/%b/%b", c, mem_req, mem_we, mem_addr, dp1_done, mem_stall);
      end else n_pass++;
    end
    // c4 : done
    tick();
    mem_ack = 0; mem_rdata = 0;
    #1;
    n_total++;
    if ({mem_req, dp1_done, dp1_err, dp1_rdata} !== {1'b0, 1'b1, 1'b0, 32'hDEADBEEF}) begin
      $display("FAIL load_done got=%b/%b/%b/%h exp=0/1/0/deadbeef", mem_req, dp1_done, dp1_err, dp1_rdata);
    end else n_pass++;
    // c5 : requester released
    tick();
    dp1_req = 0;
    #1;
    n_total++;
    if ({dp1_done, mem_stall, mem_req} !== 3'b000) begin
      $display("FAIL load_after got=%b exp=000", {dp1_done, mem_stall, mem_req});
    end else n_pass++;
  endtask

  task automatic test_timeout();
    tick();
    dp1_req = 1; dp1_we = 0; dp1_addr = 32'h200;
    for (int c = 1; c <= 4; c++) begin
      tick();
      #1;
      n_total++;
      if ({mem_req, dp1_done} !== 2'b10) begin
        $display("FAIL tmo_busy_c%0d got=%b exp=10", c, {mem_req, dp1_done});
      end else n_pass++;
    end
    tick();
    #1;
    n_total++;
    if ({mem_req, dp1_done, dp1_err, dp1_rdata} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin
      $display("FAIL tmo_done got=%b/%b/%b/%h exp=0/1/1/0", mem_req, dp1_done, dp1_err, dp1_rdata);
    end else n_pass++;
    // late ack arrives in IDLE
    tick();
    dp1_req = 0; mem_ack = 1; mem_rdata = 32'h12345678;
    #1;
    tick();
    mem_ack = 0; mem_rdata = 0;
    #1;
    n_total++;
    if ({dp1_done, dp1_err, dp2_done, mem_req, mem_stall} !== 5'b0) begin
      $display("FAIL tmo_stale_ack got=%b exp=00000", {dp1_done, dp1_err, dp2_done, mem_req, mem_stall});
    end else n_pass++;
  endtask

  task automatic test_back_to_back();
    tick();
    // c0
    dp1_req = 1; dp1_we = 1; dp1_addr = 32'h40; dp1_wdata = 32'h55;
    dp2_req = 1; dp2_we = 0; dp2_addr = 32'h40; dp2_wdata = 32'h0;
    #1;
    n_total++;
    if (mem_stall !== 1'b1) begin
      $display("FAIL b2b_stall_c0 got=%b exp=1", mem_stall);
    end else n_pass++;
    // c1 : write first
    tick();
    mem_ack = 1;
    #1;
    n_total++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_stall} !== {1'b1, 1'b1, 32'h40, 32'h55, 1'b1}) begin
      $display("FAIL b2b_write got=%b/%b/%h/%h/%b", mem_req, mem_we, mem_addr, mem_wdata, mem_stall);
    end else n_pass++;
    // c2 : DONE1
    tick();
    mem_ack = 0;
    #1;
    n_total++;
    if ({mem_req, dp1_done, dp1_err, dp1_rdata, mem_stall, dp2_done} !== {1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0}) begin
      $display("FAIL b2b_done1 got=%b/%b/%b/%h/%b/%b", mem_req, dp1_done, dp1_err, dp1_rdata, mem_stall, dp2_done);
    end else n_pass++;
    // c3 : read of the stored word
    tick();
    dp1_req = 0; mem_ack = 1; mem_rdata = 32'h55;
    #1;
    n_total++;
    if ({mem_req, mem_we, mem_addr, dp1_done, mem_stall} !== {1'b1, 1'b0, 32'h40, 1'b0, 1'b1}) begin
      $display("FAIL b2b_read got=%b/%b/%h/%b/%b", mem_req, mem_we, mem_addr, dp1_done, mem_stall);
    end else n_pass++;
    // c4 : DONE2
    tick();
    mem_ack = 0; mem_rdata = 0;
    #1;
    n_total++;
    if ({dp2_done, dp2_err, dp2_rdata, mem_stall, mem_req} !== {1'b1, 1'b0, 32'h55, 1'b0, 1'b0}) begin
      $display("FAIL b2b_done2 got=%b/%b/%h/%b/%b", dp2_done, dp2_err, dp2_rdata, mem_stall, mem_req);
    end else n_pass++;
    tick();
    dp2_req = 0;
    #1;
    n_total++;
    if ({dp2_done, dp1_done, mem_stall} !== 3'b000) begin
      $display("FAIL b2b_after got=%b exp=000", {dp2_done, dp1_done, mem_stall});
    end else n_pass++;
  endtask

  task automatic test_misaligned();
    tick();
    dp2_req = 1; dp2_we = 0; dp2_addr = 32'h103;
    #1;
    n_total++;
    if ({mem_req, mem_stall} !== 2'b01) begin
      $display("FAIL mis_c0 got=%b exp=01", {mem_req, mem_stall});
    end else n_pass++;
    tick();
    #1;
    n_total++;
    if ({mem_req, dp2_done, dp2_err, dp2_rdata, mem_stall} !== {1'b0, 1'b1, 1'b1, 32'h0, 1'b0}) begin
      $display("FAIL mis_done got=%b/%b/%b/%h/%b exp=0/1/1/0/0", mem_req, dp2_done, dp2_err, dp2_rdata, mem_stall);
    end else n_pass++;
    tick();
    dp2_req = 0;
    #1;
    n_total++;
    if ({mem_req, dp2_done, dp2_err} !== 3'b000) begin
      $display("FAIL mis_after got=%b exp=000", {mem_req, dp2_done, dp2_err});
    end else n_pass++;
  endtask

  task automatic test_ack_at_expiry();
    tick();
    dp1_req = 1; dp1_we = 0; dp1_addr = 32'h300;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 4) begin mem_ack = 1; mem_rdata = 32'hCAFEF00D; end
      #1;
      n_total++;
      if (mem_req !== 1'b1) begin
        $display("FAIL exp_busy_c%0d got=%b exp=1", c, mem_req);
      end else n_pass++;
    end
    tick();
    mem_ack = 0; mem_rdata = 0;
    #1;
    n_total++;
    if ({dp1_done, dp1_err, dp1_rdata, mem_req} !== {1'b1, 1'b0, 32'hCAFEF00D, 1'b0}) begin
      $display("FAIL exp_ack_wins got=%b/%b/%h/%b exp=1/0/cafef00d/0", dp1_done, dp1_err, dp1_rdata, mem_req);
    end else n_pass++;
    tick();
    dp1_req = 0;
    #1;
  endtask

  task automatic test_reset_mid_busy();
    tick();
    dp2_req = 1; dp2_we = 0; dp2_addr = 32'h80;
    tick();
    #1;
    n_total++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h80}) begin
      $display("FAIL rst_pre got=%b/%h exp=1/80", mem_req, mem_addr);
    end else n_pass++;
    #1;
    n_rst = 0; dp2_req = 0;
    #1;
    n_total++;
    if ({mem_req, dp2_done, dp2_err, dp1_done, dp1_err, mem_addr, mem_stall} !== {5'b0, 32'h0, 1'b0}) begin
      $display("FAIL rst_mid got=%b/%b/%b/%b/%b/%h/%b", mem_req, dp2_done, dp2_err, dp1_done, dp1_err, mem_addr, mem_stall);
    end else n_pass++;
    #1;
    n_rst = 1;
    // fresh dp1 load with nominal latency
    tick();
    dp1_req = 1; dp1_we = 0; dp1_addr = 32'h104;
    tick();
    mem_ack = 1; mem_rdata = 32'hA5A5_0001;
    #1;
    n_total++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h104}) begin
      $display("FAIL rst_fresh_req got=%b/%h exp=1/104", mem_req, mem_addr);
    end else n_pass++;
    tick();
    mem_ack = 0; mem_rdata = 0;
    #1;
    n_total++;
    if ({dp1_done, dp1_err, dp1_rdata} !== {1'b1, 1'b0, 32'hA5A5_0001}) begin
      $display("FAIL rst_fresh_done got=%b/%b/%h exp=1/0/a5a50001", dp1_done, dp1_err, dp1_rdata);
    end else n_pass++;
    tick();
    dp1_req = 0;
    #1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_single_load();
    test_timeout();
    test_back_to_back();
    test_misaligned();
    test_ack_at_expiry();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
